bram_host_loader: RTL and testbench

Host-side sequencer for the compute-RAM system's external BRAM port. It streams input words into the BRAM, then runs the compute pass and waits for it to finish. It then reads the result words back out on a valid/ready stream. It sits between a host/DMA stream and the system block's `external`/`bram_*_ext`/`start`/`done` pins.

---
 rtl/bram_host_loader.sv | 219 +++++++++++++++++++++
 tb/tb_bram_host_loader.sv | 326 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bram_host_loader.sv
// bram_host_loader: host-side sequencer for the compute-RAM external BRAM port.
// Streams a block of words into the BRAM, starts the compute pass, waits for
// it to finish, then streams a block of result words back out.
//
// Handshake rule for all three streams (cmd, in, out): a transfer happens on
// the rising clock edge where valid and ready are both high. A source holds
// its valid and data stable until that edge. Ready may depend on state only,
// never on valid.
module bram_host_loader #(
    parameter int DWIDTH = 40,
    parameter int AWIDTH = 9
) (
    input  logic              clk,
    input  logic              reset,
    // command channel
    input  logic              cmd_valid_i,
    output logic              cmd_ready_o,
    input  logic [AWIDTH-1:0] cmd_load_base_i,
    input  logic [AWIDTH-1:0] cmd_unload_base_i,
    input  logic [AWIDTH:0]   cmd_load_count_i,
    input  logic [AWIDTH:0]   cmd_unload_count_i,
    output logic              cmd_done_o,
    // load stream
    input  logic              in_valid_i,
    output logic              in_ready_o,
    input  logic [DWIDTH-1:0] in_data_i,
    // unload stream
    output logic              out_valid_o,
    input  logic              out_ready_i,
    output logic [DWIDTH-1:0] out_data_o,
    // system external BRAM port
    output logic              external_o,
    output logic              bram_sel_o,
    output logic              bram_wren_ext_o,
    output logic [AWIDTH-1:0] bram_addr_ext_o,
    output logic [DWIDTH-1:0] bram_wdata_ext_o,
    input  logic [DWIDTH-1:0] bram_rdata_ext_i,
    // system control
    output logic              sys_start_o,
    input  logic              sys_done_i,
    output logic [AWIDTH-1:0] start_addr_inputs_o,
    output logic [AWIDTH-1:0] start_addr_outputs_o,
    // current FSM state, for observation
    output logic [1:0]        state_dbg_o
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_LOAD   = 2'd1,
        S_RUN    = 2'd2,
        S_UNLOAD = 2'd3
    } state_t;

    localparam logic [AWIDTH:0] CNT_ONE = {{AWIDTH{1'b0}}, 1'b1};

    state_t            state_q, state_d;
    logic              cmd_done_q, cmd_done_d;
    logic [AWIDTH-1:0] load_base_q, load_base_d;
    logic [AWIDTH-1:0] unload_base_q, unload_base_d;
    logic [AWIDTH:0]   load_count_q, load_count_d;
    logic [AWIDTH:0]   unload_count_q, unload_count_d;
    logic [AWIDTH:0]   load_idx_q, load_idx_d;   // words written so far
    logic [AWIDTH:0]   rd_idx_q, rd_idx_d;       // reads issued so far
    logic [AWIDTH:0]   out_idx_q, out_idx_d;     // words delivered so far
    logic              inflight_q, inflight_d;   // read issued last cycle
    logic [1:0]        wr_ptr_q, wr_ptr_d;
    logic [1:0]        rd_ptr_q, rd_ptr_d;
    logic [2:0]        occ_q, occ_d;             // FIFO occupancy, 0..4
    logic [DWIDTH-1:0] fifo_mem_q [4];

    logic            load_fire;
    logic            rd_issue;
    logic            push;
    logic            pop;
    logic            fifo_nonempty;
    logic [AWIDTH:0] load_idx_inc;
    logic [AWIDTH:0] out_idx_inc;

    assign load_fire     = (state_q == S_LOAD) && in_valid_i;
    assign fifo_nonempty = (occ_q != 3'd0);
    assign pop           = fifo_nonempty && out_ready_i;
    // Read data arrives one cycle after its address, so last cycle's issue
    // is this cycle's FIFO write.
    assign push          = inflight_q;
    // Gating on occupancy plus the outstanding read keeps the 4-entry FIFO
    // from ever overflowing under backpressure.
    assign rd_issue      = (state_q == S_UNLOAD) && (rd_idx_q != unload_count_q)
                           && ((occ_q + {2'b00, inflight_q}) < 3'd4);
    assign load_idx_inc  = load_idx_q + CNT_ONE;
    assign out_idx_inc   = out_idx_q + CNT_ONE;

    // Next-state logic: FSM transitions, command capture, counters and FIFO pointers.
    always_comb begin
        state_d        = state_q;
        cmd_done_d     = 1'b0;
        load_base_d    = load_base_q;
        unload_base_d  = unload_base_q;
        load_count_d   = load_count_q;
        unload_count_d = unload_count_q;
        load_idx_d     = load_idx_q;
        rd_idx_d       = rd_idx_q;
        out_idx_d      = out_idx_q;
        inflight_d     = rd_issue;
        wr_ptr_d       = push ? wr_ptr_q + 2'd1 : wr_ptr_q;
        rd_ptr_d       = pop ? rd_ptr_q + 2'd1 : rd_ptr_q;
        occ_d          = occ_q + {2'b00, push} - {2'b00, pop};

        case (state_q)
            S_IDLE: begin
                if (cmd_valid_i) begin
                    load_base_d    = cmd_load_base_i;
                    unload_base_d  = cmd_unload_base_i;
                    load_count_d   = cmd_load_count_i;
                    unload_count_d = cmd_unload_count_i;
                    load_idx_d     = '0;
                    rd_idx_d       = '0;
                    out_idx_d      = '0;
                    state_d        = (cmd_load_count_i == '0) ? S_RUN : S_LOAD;
                end
            end
            S_LOAD: begin
                if (load_fire) begin
                    load_idx_d = load_idx_inc;
                    if (load_idx_inc == load_count_q) begin
                        state_d = S_RUN;
                    end
                end
            end
            S_RUN: begin
                if (sys_done_i) begin
                    if (unload_count_q == '0) begin
                        state_d    = S_IDLE;
                        cmd_done_d = 1'b1;
                    end else begin
                        state_d = S_UNLOAD;
                    end
                end
            end
            S_UNLOAD: begin
                if (rd_issue) begin
                    rd_idx_d = rd_idx_q + CNT_ONE;
                end
                if (pop) begin
                    out_idx_d = out_idx_inc;
                    if (out_idx_inc == unload_count_q) begin
                        state_d    = S_IDLE;
                        cmd_done_d = 1'b1;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State and control registers; reset flushes the FSM, FIFO and in-flight read.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= S_IDLE;
            cmd_done_q     <= 1'b0;
            load_base_q    <= '0;
            unload_base_q  <= '0;
            load_count_q   <= '0;
            unload_count_q <= '0;
            load_idx_q     <= '0;
            rd_idx_q       <= '0;
            out_idx_q      <= '0;
            inflight_q     <= 1'b0;
            wr_ptr_q       <= '0;
            rd_ptr_q       <= '0;
            occ_q          <= '0;
        end else begin
            state_q        <= state_d;
            cmd_done_q     <= cmd_done_d;
            load_base_q    <= load_base_d;
            unload_base_q  <= unload_base_d;
            load_count_q   <= load_count_d;
            unload_count_q <= unload_count_d;
            load_idx_q     <= load_idx_d;
            rd_idx_q       <= rd_idx_d;
            out_idx_q      <= out_idx_d;
            inflight_q     <= inflight_d;
            wr_ptr_q       <= wr_ptr_d;
            rd_ptr_q       <= rd_ptr_d;
            occ_q          <= occ_d;
        end
    end

    // FIFO storage: data only, validity is tracked by occupancy and pointers.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem_q[wr_ptr_q] <= bram_rdata_ext_i;
        end
    end

    // Output decode from the current state; BRAM write fires in the handshake cycle.
    always_comb begin
        cmd_ready_o      = (state_q == S_IDLE);
        in_ready_o       = (state_q == S_LOAD);
        sys_start_o      = (state_q == S_RUN);
        external_o       = (state_q == S_LOAD) || (state_q == S_UNLOAD);
        bram_sel_o       = (state_q == S_LOAD) || (state_q == S_UNLOAD);
        bram_wren_ext_o  = load_fire;
        bram_wdata_ext_o = load_fire ? in_data_i : '0;
        bram_addr_ext_o  = '0;
        if (state_q == S_LOAD) begin
            bram_addr_ext_o = load_base_q + load_idx_q[AWIDTH-1:0];
        end else if (state_q == S_UNLOAD) begin
            bram_addr_ext_o = unload_base_q + rd_idx_q[AWIDTH-1:0];
        end
        out_valid_o = fifo_nonempty;
        out_data_o  = fifo_nonempty ? fifo_mem_q[rd_ptr_q] : '0;
    end

    assign cmd_done_o           = cmd_done_q;
    assign start_addr_inputs_o  = load_base_q;
    assign start_addr_outputs_o = unload_base_q;
    assign state_dbg_o          = state_q;

endmodule

// File: tb/tb_bram_host_loader.sv
// Bench for bram_host_loader: BRAM and compute-system responders, a table of
// directed commands with hand-computed timing and addresses, and hand-written
// reset sequences.
module tb_bram_host_loader;

    localparam int DW     = 40;
    localparam int AW     = 9;
    localparam int DEPTH  = 512;
    localparam int BUDGET = 3000;

    // ---------------- clock / reset ----------------
    logic clk;
    logic reset;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- DUT signals ----------------
    logic          cmd_valid, cmd_ready, cmd_done;
    logic [AW-1:0] cmd_load_base, cmd_unload_base;
    logic [AW:0]   cmd_load_count, cmd_unload_count;
    logic          in_valid, in_ready;
    logic [DW-1:0] in_data;
    logic          out_valid, out_ready;
    logic [DW-1:0] out_data;
    logic          external_s, bram_sel, bram_wren_ext;
    logic [AW-1:0] bram_addr_ext;
    logic [DW-1:0] bram_wdata_ext, bram_rdata_ext;
    logic          sys_start, sys_done;
    logic [AW-1:0] start_addr_inputs, start_addr_outputs;
    logic [1:0]    state_dbg;

    bram_host_loader #(.DWIDTH(DW), .AWIDTH(AW)) dut (
        .clk                  (clk),
        .reset                (reset),
        .cmd_valid_i          (cmd_valid),
        .cmd_ready_o          (cmd_ready),
        .cmd_load_base_i      (cmd_load_base),
        .cmd_unload_base_i    (cmd_unload_base),
        .cmd_load_count_i     (cmd_load_count),
        .cmd_unload_count_i   (cmd_unload_count),
        .cmd_done_o           (cmd_done),
        .in_valid_i           (in_valid),
        .in_ready_o           (in_ready),
        .in_data_i            (in_data),
        .out_valid_o          (out_valid),
        .out_ready_i          (out_ready),
        .out_data_o           (out_data),
        .external_o           (external_s),
        .bram_sel_o           (bram_sel),
        .bram_wren_ext_o      (bram_wren_ext),
        .bram_addr_ext_o      (bram_addr_ext),
        .bram_wdata_ext_o     (bram_wdata_ext),
        .bram_rdata_ext_i     (bram_rdata_ext),
        .sys_start_o          (sys_start),
        .sys_done_i           (sys_done),
        .start_addr_inputs_o  (start_addr_inputs),
        .start_addr_outputs_o (start_addr_outputs),
        .state_dbg_o          (state_dbg)
    );

    // ---------------- responders ----------------
    logic [DW-1:0] bram [DEPTH];
    logic [DW-1:0] shadow [DEPTH];   // what the bench intends each address to hold
    logic          bram_init;
    int            done_delay;
    int            done_cnt;

    function automatic logic [DW-1:0] pattern(input int a);
        logic [DW-1:0] p;
        p = 40'hC3_0000_0000;
        p[15:0] = a[15:0];
        return p;
    endfunction

    function automatic logic [DW-1:0] word_of(input logic [DW-1:0] seed, input int k);
        logic [DW-1:0] m;
        m = DW'(k + 1);
        return seed * m;
    endfunction

    // BRAM with 1-cycle registered read
    always @(posedge clk) begin
        if (bram_init) begin
            for (int a = 0; a < DEPTH; a++) bram[a] <= pattern(a);
        end else if (bram_wren_ext) begin
            bram[bram_addr_ext] <= bram_wdata_ext;
        end
        bram_rdata_ext <= bram[bram_addr_ext];
    end

    // compute system: pulses done done_delay cycles after start rises
    always @(posedge clk) begin
        sys_done <= 1'b0;
        if (reset) begin
            done_cnt <= 0;
        end else if (sys_start && !sys_done) begin
            if (done_cnt + 1 == done_delay) begin
                sys_done <= 1'b1;
                done_cnt <= 0;
            end else begin
                done_cnt <= done_cnt + 1;
            end
        end else begin
            done_cnt <= 0;
        end
    end

    // ---------------- scoreboard ----------------
    int checks;
    int failures;
    logic [DW-1:0] exp_q[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_cmd_ready"}, 64'(cmd_ready), 64'd1);
        check({tag, "_cmd_done"}, 64'(cmd_done), 64'd0);
        check({tag, "_in_ready"}, 64'(in_ready), 64'd0);
        check({tag, "_out_valid"}, 64'(out_valid), 64'd0);
        check({tag, "_out_data"}, 64'(out_data), 64'd0);
        check({tag, "_external"}, 64'(external_s), 64'd0);
        check({tag, "_bram_sel"}, 64'(bram_sel), 64'd0);
        check({tag, "_wren"}, 64'(bram_wren_ext), 64'd0);
        check({tag, "_addr"}, 64'(bram_addr_ext), 64'd0);
        check({tag, "_wdata"}, 64'(bram_wdata_ext), 64'd0);
        check({tag, "_sys_start"}, 64'(sys_start), 64'd0);
        check({tag, "_sa_in"}, 64'(start_addr_inputs), 64'd0);
        check({tag, "_sa_out"}, 64'(start_addr_outputs), 64'd0);
        check({tag, "_state"}, 64'(state_dbg), 64'd0);
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic [AW-1:0] lb;
        int            lc;
        logic [AW-1:0] ub;
        int            uc;
        int            delay;
        bit            bp;
        logic [DW-1:0] seed;
        int            exp_start;      // cycle (after accept) sys_start first high
        int            exp_first_out;  // cycle of first out_valid, -1 if none
        int            exp_cmd_done;   // cycle of cmd_done (ignored with backpressure)
        logic [AW-1:0] exp_first_wa;
        logic [AW-1:0] exp_last_wa;
    } vec_t;

    vec_t vecs[7];

    task automatic drive_cmd(input vec_t v);
        cmd_load_base    = v.lb;
        cmd_unload_base  = v.ub;
        cmd_load_count   = (AW+1)'(v.lc);
        cmd_unload_count = (AW+1)'(v.uc);
        done_delay       = v.delay;
        cmd_valid        = 1'b1;
    endtask

    task automatic run_vec(input vec_t v, input string tag);
        int k, wr_n, out_n, werr, stray, unstable;
        int start_cyc, fall_cyc, sd_cyc, first_out, done_cyc;
        bit prev_stall;
        logic [DW-1:0] prev_data, exp_w;
        logic [AW-1:0] exp_a, first_wa, last_wa;
        k = 0; wr_n = 0; out_n = 0; werr = 0; stray = 0; unstable = 0;
        start_cyc = -1; fall_cyc = -1; sd_cyc = -1; first_out = -1; done_cyc = -1;
        prev_stall = 1'b0; prev_data = '0; first_wa = '0; last_wa = '0;

        @(posedge clk); #1;
        drive_cmd(v);
        @(negedge clk);
        check({tag, "_cmd_ready"}, 64'(cmd_ready), 64'd1);

        for (int cyc = 1; cyc <= BUDGET; cyc++) begin
            @(posedge clk); #1;
            cmd_valid = 1'b0;
            in_valid  = (k < v.lc);
            in_data   = word_of(v.seed, k);
            out_ready = v.bp ? 1'($urandom_range(0, 1)) : 1'b1;
            @(negedge clk);
            if (bram_wren_ext) begin
                if (!(in_valid && in_ready)) stray++;
                exp_a = AW'((int'(v.lb) + wr_n) % DEPTH);
                if (bram_addr_ext !== exp_a) werr++;
                if (bram_wdata_ext !== word_of(v.seed, wr_n)) werr++;
                if (wr_n == 0) first_wa = bram_addr_ext;
                last_wa = bram_addr_ext;
                wr_n++;
            end
            if (in_valid && in_ready) begin
                shadow[(int'(v.lb) + k) % DEPTH] = in_data;
                k++;
            end
            if (sys_start && start_cyc < 0) begin
                start_cyc = cyc;
                for (int j = 0; j < v.uc; j++) exp_q.push_back(shadow[(int'(v.ub) + j) % DEPTH]);
            end
            if (start_cyc >= 0 && !sys_start && fall_cyc < 0) fall_cyc = cyc;
            if (sys_done && sd_cyc < 0) sd_cyc = cyc;
            if (out_valid) begin
                if (first_out < 0) first_out = cyc;
                if (prev_stall && out_data !== prev_data) unstable++;
                if (out_ready) begin
                    if (exp_q.size() == 0) begin
                        check({tag, "_out_extra"}, 64'(out_n + 1), 64'(v.uc));
                    end else begin
                        exp_w = exp_q.pop_front();
                        check($sformatf("%s_out_word%0d", tag, out_n), 64'(out_data), 64'(exp_w));
                    end
                    out_n++;
                end
            end
            prev_stall = out_valid && !out_ready;
            prev_data  = out_data;
            if (cmd_done) begin
                done_cyc = cyc;
                check({tag, "_ready_at_done"}, 64'(cmd_ready), 64'd1);
                break;
            end
        end

        check({tag, "_cmd_done_seen"}, 64'(done_cyc >= 0), 64'd1);
        check({tag, "_load_words"}, 64'(wr_n), 64'(v.lc));
        check({tag, "_write_errs"}, 64'(werr), 64'd0);
        check({tag, "_stray_write"}, 64'(stray), 64'd0);
        if (v.lc > 0) begin
            check({tag, "_first_waddr"}, 64'(first_wa), 64'(v.exp_first_wa));
            check({tag, "_last_waddr"}, 64'(last_wa), 64'(v.exp_last_wa));
        end
        check({tag, "_start_cycle"}, 64'(start_cyc), 64'(v.exp_start));
        check({tag, "_start_fall"}, 64'(fall_cyc), 64'(sd_cyc + 1));
        check({tag, "_first_out"}, 64'(first_out), 64'(v.exp_first_out));
        check({tag, "_out_words"}, 64'(out_n), 64'(v.uc));
        check({tag, "_out_stable"}, 64'(unstable), 64'd0);
        if (!v.bp) check({tag, "_done_cycle"}, 64'(done_cyc), 64'(v.exp_cmd_done));
        check({tag, "_exp_left"}, 64'(exp_q.size()), 64'd0);
        exp_q.delete();

        @(posedge clk); #1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        @(negedge clk);
        check({tag, "_done_pulse"}, 64'(cmd_done), 64'd0);
        check({tag, "_idle_ready"}, 64'(cmd_ready), 64'd1);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        checks = 0; failures = 0;
        reset = 1'b1; bram_init = 1'b1; done_delay = 1;
        cmd_valid = 1'b0; cmd_load_base = '0; cmd_unload_base = '0;
        cmd_load_count = '0; cmd_unload_count = '0;
        in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
        for (int a = 0; a < DEPTH; a++) shadow[a] = pattern(a);

        //        lb     lc   ub     uc   dly  bp  seed         start first done  fwa    lwa
        vecs[0] = '{9'd0,   4,   9'd100, 4,   512, 0, 40'h201,     5,    520,  524,  9'd0,   9'd3};
        vecs[1] = '{9'd510, 4,   9'd511, 2,   3,   0, 40'h1111,    5,    11,   13,   9'd510, 9'd1};
        vecs[2] = '{9'd20,  16,  9'd20,  16,  5,   1, 40'h30303,   17,   25,   0,    9'd20,  9'd35};
        vecs[3] = '{9'd7,   0,   9'd30,  3,   2,   0, 40'h5,       1,    6,    9,    9'd0,   9'd0};
        vecs[4] = '{9'd40,  2,   9'd45,  0,   4,   0, 40'h777,     3,    -1,   8,    9'd40,  9'd41};
        vecs[5] = '{9'd3,   0,   9'd4,   0,   1,   0, 40'h9,       1,    -1,   3,    9'd0,   9'd0};
        vecs[6] = '{9'd300, 512, 9'd5,   512, 2,   0, 40'hAB_CDEF, 513,  518,  1030, 9'd300, 9'd299};

        // reset values after two cycles of reset
        repeat (2) @(posedge clk);
        #1 bram_init = 1'b0;
        @(negedge clk);
        check_reset_outputs("por");
        reset = 1'b0;

        for (int i = 0; i < 7; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

        // reset while in RUN
        @(posedge clk); #1;
        drive_cmd('{9'd60, 0, 9'd70, 2, 1000, 0, 40'h1, 1, -1, 0, 9'd0, 9'd0});
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_run_pre_start", 64'(sys_start), 64'd1);
        check("rst_run_pre_sa_in", 64'(start_addr_inputs), 64'd60);
        check("rst_run_pre_sa_out", 64'(start_addr_outputs), 64'd70);
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check_reset_outputs("rst_run");
        reset = 1'b0;

        // reset while in UNLOAD with three words buffered and one read in flight
        @(posedge clk); #1;
        drive_cmd('{9'd0, 0, 9'd50, 8, 2, 0, 40'h1, 1, -1, 0, 9'd0, 9'd0});
        out_ready = 1'b0;
        for (int cyc = 1; cyc <= 8; cyc++) begin
            @(posedge clk); #1;
            cmd_valid = 1'b0;
            @(negedge clk);
            if (cyc == 5) check("unl_not_yet_valid", 64'(out_valid), 64'd0);
            if (cyc == 6) begin
                check("unl_first_valid", 64'(out_valid), 64'd1);
                check("unl_first_data", 64'(out_data), 64'(shadow[50]));
            end
        end
        check("unl_state", 64'(state_dbg), 64'd3);
        check("unl_held_data", 64'(out_data), 64'(shadow[50]));
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check_reset_outputs("rst_unload");
        reset = 1'b0;

        // a following command completes normally
        run_vec(vecs[1], "after_rst");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
